scan_readback: RTL and testbench
================================

SCAN_READBACK -- requirements
Module: scan_readback

Interface
REQ-001 The block SHALL have parameter CHAIN_LENGTH, default 64: the number of scan-chain bits read per readback.
REQ-002 The block SHALL have parameter WORD_WIDTH, default 32: the output word size in bits.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4: the output word buffer depth, a power of two.
REQ-004 Port list:
- PCLK  in  1  single clock; all logic on its rising edge.
- PRST  in  1  synchronous, active-high reset.
- START  in  1  one-cycle pulse; begins a readback.
- SE  out  1  scan shift enable to the chain.
- SOUT  in  1  chain tail bit.
- SIN  out  1  chain head bit (recirculation).
- WORD_DATA  out  WORD_WIDTH  head word of the FIFO.
- WORD_VALID  out  1  FIFO not empty.
- WORD_READY  in  1  consumer accepts the word.
- BUSY  out  1  a readback is in progress.
- DONE  out  1  one-cycle pulse when the readback completes.
- CRC  out  32  chain CRC (see Configuration).

Function
REQ-005 The FSM SHALL have the states IDLE, SHIFT, STALL, FLUSH and FINISH.
REQ-006 IDLE->SHIFT SHALL occur on START; START in any other state SHALL be ignored.
REQ-007 SE SHALL be high only in SHIFT; each SE-high edge consumes exactly one bit.
REQ-008 On each SE-high edge, the current SOUT SHALL be written into the assembly register at bit index bitcount mod WORD_WIDTH, LSB first.
REQ-009 SIN SHALL equal SOUT combinationally, so that after CHAIN_LENGTH shifts the chain contents are unchanged.
REQ-010 A full word SHALL be pushed into the FIFO on the edge that writes its MSB.
REQ-011 SHIFT->STALL SHALL occur when the FIFO is full and the next bit would complete a word; STALL->SHIFT SHALL occur on the first cycle the FIFO has space.
REQ-012 After CHAIN_LENGTH bits, if CHAIN_LENGTH mod WORD_WIDTH != 0, the FSM SHALL go to FLUSH and push the partial word with zero-padded upper bits once FIFO space exists; otherwise it SHALL go directly to FINISH.
REQ-013 FINISH SHALL pulse DONE for one cycle, then return to IDLE.
REQ-014 BUSY SHALL be high in every state except IDLE.
REQ-015 FIFO behaviour:
- A pop SHALL occur when WORD_VALID && WORD_READY.
- A simultaneous push and pop when full SHALL be legal.
- Pointers SHALL wrap modulo FIFO_DEPTH.
- WORD_DATA SHALL be first-word-fall-through.
REQ-016 Words remaining in the FIFO after DONE SHALL stay available; a new START SHALL not clear them.

Reset
REQ-017 When PRST is high, the following SHALL hold after the next edge: state IDLE; SE, BUSY, DONE and WORD_VALID = 0; bit counter and assembly register = 0; FIFO empty; CRC = 0.
REQ-018 A reset during SHIFT SHALL drop SE at that edge; a partial chain rotation is accepted and not repaired.

Configuration
REQ-019 Macro SCAN_READBACK_CRC_EN: when defined, CRC SHALL hold a CRC-32 (poly 0x04C11DB7, init 0xFFFFFFFF, no final XOR) updated with each consumed SOUT bit, cleared on START, stable from DONE until the next START.
REQ-020 When SCAN_READBACK_CRC_EN is undefined, CRC SHALL be constant 0 and no CRC logic SHALL be built.

Verification
REQ-021 With CHAIN_LENGTH=64, a chain model preloaded with 0xDEADBEEF_01234567 (bit 0 first out), and WORD_READY=1: words 0x01234567 then 0xDEADBEEF; DONE 64+ cycles after START; chain model contents unchanged.
REQ-022 With CHAIN_LENGTH=40 and all-ones chain data: words 0xFFFFFFFF then 0x000000FF; FLUSH visited once.
REQ-023 With CHAIN_LENGTH=256, FIFO_DEPTH=4 and WORD_READY=0 for 200 cycles: SE drops after 128 bits, the FIFO holds 4 words, and shifting resumes on release; all 8 words correct, no bit lost or duplicated.
REQ-024 With PRST asserted at bit 17: SE=0, WORD_VALID=0, BUSY=0 next cycle; a following START performs a full, correct readback.
REQ-025 With SCAN_READBACK_CRC_EN defined and the 64-bit pattern of REQ-021: CRC matches the reference model value at DONE; START pulsed while BUSY causes no effect.

Source files
------------

// File: rtl/scan_readback.sv
// Scan-chain readback: shifts a recirculating chain into a word FIFO.
// Define SCAN_READBACK_CRC_EN to build the serial CRC-32 over the chain bits.
module scan_readback #(
  parameter int CHAIN_LENGTH = 64,
  parameter int WORD_WIDTH   = 32,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  PCLK,
  input  logic                  PRST,
  input  logic                  START,
  output logic                  SE,
  input  logic                  SOUT,
  output logic                  SIN,
  output logic [WORD_WIDTH-1:0] WORD_DATA,
  output logic                  WORD_VALID,
  input  logic                  WORD_READY,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [31:0]           CRC
);

  localparam int CW = $clog2(CHAIN_LENGTH + 1);
  localparam int WW = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FW = $clog2(FIFO_DEPTH + 1);
  localparam bit HAS_TAIL = (CHAIN_LENGTH % WORD_WIDTH) != 0;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    STALL,
    FLUSH,
    FINISH
  } state_e;

  state_e state_q, state_d;

  logic [CW-1:0]         bitcnt_q, bitcnt_d;
  logic [WW-1:0]         widx_q, widx_d;
  logic [WORD_WIDTH-1:0] asm_q, asm_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [FW-1:0]         fill_q, fill_d;
  logic [WORD_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic                  shift_en;
  logic                  word_end;
  logic                  last_bit;
  logic                  push;
  logic                  pop;
  logic                  space;
  logic                  full_next;
  logic                  stall_next;
  logic [WORD_WIDTH-1:0] word_bits;
  logic [WORD_WIDTH-1:0] push_data;

  function automatic logic [PW-1:0] ptr_inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign shift_en   = state_q == SHIFT;
  assign word_end   = widx_q == WW'(WORD_WIDTH - 1);
  assign last_bit   = bitcnt_q == CW'(CHAIN_LENGTH - 1);
  assign pop        = WORD_VALID && WORD_READY;
  assign space      = (fill_q != FW'(FIFO_DEPTH)) || pop;
  assign full_next  = fill_d == FW'(FIFO_DEPTH);
  // Pause at a word boundary or just before a completing bit
  assign stall_next = full_next &&
                      (widx_d == '0 ||
                       widx_d == WW'(WORD_WIDTH - 1));

  assign SIN        = SOUT;
  assign WORD_DATA  = mem_q[rd_ptr_q];
  assign WORD_VALID = fill_q != '0;

  always_comb begin
    asm_d     = asm_q;
    widx_d    = widx_q;
    bitcnt_d  = bitcnt_q;
    push      = 1'b0;
    word_bits = asm_q;
    push_data = asm_q;
    if (state_q == IDLE && START) begin
      asm_d    = '0;
      widx_d   = '0;
      bitcnt_d = '0;
    end else if (shift_en) begin
      word_bits[widx_q] = SOUT;
      bitcnt_d = bitcnt_q + CW'(1);
      if (word_end) begin
        push      = 1'b1;
        push_data = word_bits;
        asm_d     = '0;
        widx_d    = '0;
      end else begin
        asm_d  = word_bits;
        widx_d = widx_q + WW'(1);
      end
    end else if (state_q == FLUSH && space) begin
      push      = 1'b1;
      push_data = asm_q;
      asm_d     = '0;
      widx_d    = '0;
    end
  end

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    fill_d   = fill_q;
    if (push && !pop) begin
      fill_d = fill_q + FW'(1);
    end else if (!push && pop) begin
      fill_d = fill_q - FW'(1);
    end
  end

  always_ff @(posedge PCLK) begin
    if (push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      bitcnt_q <= '0;
      widx_q   <= '0;
      asm_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      bitcnt_q <= bitcnt_d;
      widx_q   <= widx_d;
      asm_q    <= asm_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (START) begin
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          state_d = HAS_TAIL ? FLUSH : FINISH;
        end else if (stall_next) begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (fill_q != FW'(FIFO_DEPTH)) begin
          state_d = SHIFT;
        end
      end
      FLUSH: begin
        if (space) begin
          state_d = FINISH;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    SE   = 1'b0;
    BUSY = 1'b1;
    DONE = 1'b0;
    unique case (state_q)
      IDLE:    BUSY = 1'b0;
      SHIFT:   SE   = 1'b1;
      FINISH:  DONE = 1'b1;
      default: BUSY = 1'b1;
    endcase
  end

`ifdef SCAN_READBACK_CRC_EN
  localparam logic [31:0] POLY = 32'h04C1_1DB7;

  logic [31:0] crc_q, crc_d;
  logic        crc_fb;

  assign crc_fb = crc_q[31] ^ SOUT;

  always_comb begin
    crc_d = crc_q;
    if (state_q == IDLE && START) begin
      crc_d = 32'hFFFF_FFFF;
    end else if (shift_en) begin
      crc_d = {crc_q[30:0], 1'b0} ^
              (crc_fb ? POLY : 32'h0);
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRST) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign CRC = crc_q;
`else
  assign CRC = '0;
`endif

endmodule

// File: tb/tb_scan_readback.sv
// Bench for scan_readback: three chain lengths (64, 40, 256),
// chain models, word scoreboard, reset and backpressure sequences.
module tb_scan_readback;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]   prst, start, se, sout, sin;
  logic [2:0]   wv, wr, busy, done, load;
  logic [31:0]  wd  [3];
  logic [31:0]  crc [3];
  logic [255:0] chain [3];
  logic [255:0] lval;

  int checks = 0;
  int fails  = 0;
  int se_cnt = 0;
  int done_cnt = 0;
  logic [31:0] sbq [$];

  scan_readback #(.CHAIN_LENGTH(64)) u0 (
    .PCLK(clk), .PRST(prst[0]), .START(start[0]),
    .SE(se[0]), .SOUT(sout[0]), .SIN(sin[0]),
    .WORD_DATA(wd[0]), .WORD_VALID(wv[0]),
    .WORD_READY(wr[0]), .BUSY(busy[0]),
    .DONE(done[0]), .CRC(crc[0])
  );

  scan_readback #(.CHAIN_LENGTH(40)) u1 (
    .PCLK(clk), .PRST(prst[1]), .START(start[1]),
    .SE(se[1]), .SOUT(sout[1]), .SIN(sin[1]),
    .WORD_DATA(wd[1]), .WORD_VALID(wv[1]),
    .WORD_READY(wr[1]), .BUSY(busy[1]),
    .DONE(done[1]), .CRC(crc[1])
  );

  scan_readback #(.CHAIN_LENGTH(256), .FIFO_DEPTH(4)) u2 (
    .PCLK(clk), .PRST(prst[2]), .START(start[2]),
    .SE(se[2]), .SOUT(sout[2]), .SIN(sin[2]),
    .WORD_DATA(wd[2]), .WORD_VALID(wv[2]),
    .WORD_READY(wr[2]), .BUSY(busy[2]),
    .DONE(done[2]), .CRC(crc[2])
  );

  function automatic int len_of(input int u);
    case (u)
      0:       return 64;
      1:       return 40;
      default: return 256;
    endcase
  endfunction

  function automatic logic [255:0] mask_of(input int l);
    return (256'd1 << l) - 256'd1;
  endfunction

  function automatic logic [255:0] rot(
    input logic [255:0] c, input logic b, input int l
  );
    logic [255:0] r;
    r = c >> 1;
    r[l-1] = b;
    return r & mask_of(l);
  endfunction

  function automatic logic [31:0] crc_ref(
    input logic [255:0] p, input int l
  );
    logic [31:0] c;
    logic fb;
    c = 32'hFFFF_FFFF;
    for (int i = 0; i < l; i++) begin
      fb = c[31] ^ p[i];
      c = {c[30:0], 1'b0} ^ (fb ? 32'h04C1_1DB7 : 32'h0);
    end
    return c;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_chain
    assign sout[g] = chain[g][0];
    always @(posedge clk) begin
      if (load[g]) chain[g] <= lval;
      else if (se[g]) chain[g] <= rot(chain[g], sin[g], len_of(g));
    end
  end

  task automatic chk(
    input string nm, input logic [255:0] act, input logic [255:0] exp
  );
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One cycle: sample at negedge, return just after the next posedge.
  task automatic step(input int u);
    logic [31:0] e;
    @(negedge clk);
    if (se[u] === 1'b1) se_cnt++;
    if (done[u] === 1'b1) done_cnt++;
    if (prst[u] === 1'b0 && wv[u] === 1'b1 && wr[u] === 1'b1) begin
      if (sbq.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_word: got %0h expected none", wd[u]);
      end else begin
        e = sbq.pop_front();
        chk("word", 256'(wd[u]), 256'(e));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run(
    input int u, input logic [255:0] pin,
    input int hold, input bit drain, input bit poke
  );
    int l, nw, cyc, dcyc, se0, d0;
    bit got;
    logic [255:0] pat;
    logic [31:0] w;
    l = len_of(u);
    nw = (l + 31) / 32;
    pat = pin & mask_of(l);
    lval = pat;
    load[u] = 1'b1;
    step(u);
    load[u] = 1'b0;
    for (int i = 0; i < nw; i++) begin
      w = pat[i*32 +: 32];
      sbq.push_back(w);
    end
    wr[u] = (hold == 0);
    se0 = se_cnt;
    d0 = done_cnt;
    got = 1'b0;
    dcyc = -1;
    start[u] = 1'b1;
    step(u);
    start[u] = 1'b0;
    cyc = 0;
    while (cyc < 4000) begin
      if (hold > 0 && cyc == hold) wr[u] = 1'b1;
      start[u] = poke && (cyc == 10);
      step(u);
      if (!got && done_cnt != d0) begin
        got = 1'b1;
        dcyc = cyc;
      end
      if (hold > 0 && cyc == hold - 1 && l > 128) begin
        chk("stall_bits", 256'(se_cnt - se0), 256'(128));
        chk("stall_se", 256'(se[u]), 256'(0));
        chk("stall_valid", 256'(wv[u]), 256'(1));
      end
      if (got && (!drain || (wr[u] && sbq.size() == 0))) break;
      cyc++;
    end
    start[u] = 1'b0;
    chk("done_seen", 256'(got), 256'(1));
    chk("bits_consumed", 256'(se_cnt - se0), 256'(l));
    chk("done_pulses", 256'(done_cnt - d0), 256'(1));
    if (hold == 0)
      chk("done_latency", 256'(dcyc + 1),
          256'(l + 1 + ((l % 32) != 0 ? 1 : 0)));
    chk("chain_intact", chain[u], pat);
    chk("busy_after", 256'(busy[u]), 256'(0));
    if (drain) begin
      chk("words_left", 256'(sbq.size()), 256'(0));
      chk("fifo_drained", 256'(wv[u]), 256'(0));
    end
`ifdef SCAN_READBACK_CRC_EN
    chk("crc", 256'(crc[u]), 256'(crc_ref(pat, l)));
`else
    chk("crc_zero", 256'(crc[u]), 256'(0));
`endif
  endtask

  typedef struct {
    int           u;
    logic [255:0] pat;
    int           hold;
    bit           drain;
    bit           poke;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [255:0] r;
    int se0;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    vt[0] = '{0, 256'hDEADBEEF_01234567, 0, 1'b1, 1'b1};
    vt[1] = '{1, 256'hFF_FFFFFFFF, 0, 1'b1, 1'b0};
    vt[2] = '{2, r, 200, 1'b1, 1'b0};
    vt[3] = '{0, 256'h0, 0, 1'b1, 1'b0};
    vt[4] = '{0, 256'hFFFF0000_AAAA5555, 3, 1'b1, 1'b0};
    vt[5] = '{1, 256'hA5_12345678, 0, 1'b1, 1'b0};

    prst = '1;
    start = '0;
    wr = '1;
    load = '0;
    lval = '0;
    step(0);
    step(0);
    for (int u = 0; u < 3; u++) begin
      chk("rst_se", 256'(se[u]), 256'(0));
      chk("rst_busy", 256'(busy[u]), 256'(0));
      chk("rst_done", 256'(done[u]), 256'(0));
      chk("rst_valid", 256'(wv[u]), 256'(0));
      chk("rst_crc", 256'(crc[u]), 256'(0));
    end
    prst = '0;
    step(0);

    for (int i = 0; i < 6; i++)
      run(vt[i].u, vt[i].pat, vt[i].hold, vt[i].drain, vt[i].poke);

    // Words left over after DONE must survive a new START.
    run(0, 256'h13579BDF_2468ACE0, 100000, 1'b0, 1'b0);
    chk("left_valid", 256'(wv[0]), 256'(1));
    run(0, 256'hCAFEF00D_0BADBEEF, 5, 1'b1, 1'b0);

    // Reset in the middle of a shift, then a clean readback.
    lval = 256'h89ABCDEF_76543210;
    load[0] = 1'b1;
    step(0);
    load[0] = 1'b0;
    wr[0] = 1'b1;
    se0 = se_cnt;
    start[0] = 1'b1;
    step(0);
    start[0] = 1'b0;
    for (int k = 0; k < 100 && se_cnt - se0 < 17; k++) step(0);
    chk("mid_bit17", 256'(se_cnt - se0), 256'(17));
    prst[0] = 1'b1;
    step(0);
    chk("mid_rst_se", 256'(se[0]), 256'(0));
    chk("mid_rst_valid", 256'(wv[0]), 256'(0));
    chk("mid_rst_busy", 256'(busy[0]), 256'(0));
    chk("mid_rst_crc", 256'(crc[0]), 256'(0));
    prst[0] = 1'b0;
    step(0);
    run(0, 256'h89ABCDEF_76543210, 0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
